// File: rtl/mem_cmd_issuer.sv
// Host-side command initiator for the image memory controller: validates packed
// instructions, runs the enable/done handshake, tracks image scale. Optional watchdog: CMD_TIMEOUT_EN.
module mem_cmd_issuer #(
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [27:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mc_done,
    input  logic [7:0]  mc_color_rd,
    output logic        mc_enable,
    output logic [2:0]  mc_operation,
    output logic [16:0] mc_addr_base,
    output logic [7:0]  mc_color_wr,
    output logic [2:0]  mc_zoom,
    output logic [7:0]  read_data,
    output logic        read_valid,
    output logic        busy,
    output logic [1:0]  err_code,
    output logic [1:0]  scale_level
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_COMPLETE, S_ERROR
    } state_t;

    localparam logic [2:0] OP_RD = 3'b001, OP_WR = 3'b010, OP_NHI = 3'b011, OP_NH = 3'b101;

    state_t      r_state, w_next;
    logic [2:0]  r_op;
    logic [16:0] r_addr;
    logic [7:0]  r_color;
    logic        r_zsel;
    logic [7:0]  r_read_data;
    logic        r_read_valid;
    logic [1:0]  r_err;
    logic [1:0]  r_scale;
    logic [2:0]  r_mc_op;
    logic [16:0] r_mc_addr;
    logic [7:0]  r_mc_color;
    logic [2:0]  r_mc_zoom;

    logic        w_accept;
    logic        w_illegal;
    logic        w_zoom_err;
    logic [1:0]  w_chk_err;
    logic        w_tmo;
    logic        w_waiting;

    assign instr_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept     = instr_valid && instr_ready;
    assign busy         = (r_state != S_IDLE);
    assign mc_enable    = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK);
    assign mc_operation = r_mc_op;
    assign mc_addr_base = r_mc_addr;
    assign mc_color_wr  = r_mc_color;
    assign mc_zoom      = r_mc_zoom;
    assign read_data    = r_read_data;
    assign read_valid   = r_read_valid;
    assign err_code     = r_err;
    assign scale_level  = r_scale;
    assign w_waiting    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);

    assign w_illegal  = !((r_op == OP_RD) || (r_op == OP_WR) || (r_op == OP_NHI) || (r_op == OP_NH));
    assign w_zoom_err = ((r_op == OP_NHI) && (r_scale == 2'd3)) ||
                        ((r_op == OP_NH) &&  r_zsel && (r_scale == 2'd0)) ||
                        ((r_op == OP_NH) && !r_zsel && (r_scale < 2'd2));
    assign w_chk_err  = w_illegal ? 2'b01 : (w_zoom_err ? 2'b10 : 2'b00);

`ifdef CMD_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] r_tmo;

    // Counts wait-state cycles since ISSUE; the last allowed cycle forces ERROR.
    always_ff @(posedge clock) begin
        if (reset)                     r_tmo <= '0;
        else if (r_state == S_ISSUE)   r_tmo <= '0;
        else if (w_waiting)            r_tmo <= r_tmo + 20'd1;
    end
    assign w_tmo = w_waiting && (r_tmo == TMO_LAST);
`else
    // Without the watchdog the limit is unused and the wait is unbounded.
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = S_CHECK;
            S_CHECK:     if (w_chk_err != 2'b00) w_next = S_ERROR;
                         else if (mc_done)       w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_ACK;
            S_WAIT_ACK:  if (w_tmo)         w_next = S_ERROR;
                         else if (!mc_done) w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (w_tmo)        w_next = S_ERROR;
                         else if (mc_done) w_next = S_COMPLETE;
            S_COMPLETE:  w_next = S_IDLE;
            S_ERROR:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_addr       <= '0;
            r_color      <= '0;
            r_zsel       <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_err        <= 2'b00;
            r_scale      <= 2'd2;
            r_mc_op      <= '0;
            r_mc_addr    <= '0;
            r_mc_color   <= '0;
            r_mc_zoom    <= '0;
        end else begin
            r_state      <= w_next;
            r_read_valid <= 1'b0;
            if (w_accept) begin
                r_op    <= instr_in[2:0];
                r_addr  <= instr_in[19:3];
                r_color <= instr_in[27:20];
                r_zsel  <= instr_in[20];
                r_err   <= 2'b00;
            end
            if (r_state == S_CHECK && w_next == S_ERROR)
                r_err <= w_chk_err;
            if (w_waiting && w_next == S_ERROR)
                r_err <= 2'b11;
            // Controller-facing fields are captured once and held through the handshake.
            if (r_state == S_CHECK && w_next == S_ISSUE) begin
                r_mc_op    <= r_op;
                r_mc_addr  <= r_addr;
                r_mc_color <= r_color;
                r_mc_zoom  <= (r_op == OP_NH) ? (r_zsel ? 3'b100 : 3'b010) : 3'b000;
            end
            if (r_state == S_COMPLETE) begin
                case (r_op)
                    OP_RD: begin
                        r_read_data  <= mc_color_rd;
                        r_read_valid <= 1'b1;
                    end
                    OP_NHI:  r_scale <= r_scale + 2'd1;
                    OP_NH:   r_scale <= r_zsel ? (r_scale - 2'd1) : (r_scale - 2'd2);
                    default: ;
                endcase
            end
        end
    end
endmodule
